// File: rtl/dispense_sequencer_pkg.sv
// Shared types and helpers for the bottle dispense sequencer.
// State encoding, channel count and one-hot select decoding.
package disp_pkg;

  localparam int NUM_CH = 4;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    POUR,
    DRIP,
    DONE,
    HOLD
  } state_t;

  function automatic logic is_onehot4(
    input logic [NUM_CH-1:0] s
  );
    return $onehot(s);
  endfunction

  function automatic logic [1:0] onehot_to_idx(
    input logic [NUM_CH-1:0] s
  );
    logic [1:0] idx;
    idx = 2'd0;
    unique case (1'b1)
      s[0]: idx = 2'd0;
      s[1]: idx = 2'd1;
      s[2]: idx = 2'd2;
      s[3]: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/dispense_sequencer_if.sv
// Request/drive bundle between mainctrl and the sequencer.
// mainctrl is the master; the sequencer is the slave.
interface dispense_sequencer_if;
  import disp_pkg::*;

  logic              out_ctrl;
  logic [NUM_CH-1:0] out_sel;
  logic [NUM_CH-1:0] valve;
  logic              pump_en;
  logic              busy;
  logic              done;
  logic              aborted;
  logic              sel_err;

  modport master (
    output out_ctrl,
    output out_sel,
    input  valve,
    input  pump_en,
    input  busy,
    input  done,
    input  aborted,
    input  sel_err
  );

  modport slave (
    input  out_ctrl,
    input  out_sel,
    output valve,
    output pump_en,
    output busy,
    output done,
    output aborted,
    output sel_err
  );

endinterface

// File: rtl/dispense_sequencer_timer.sv
// Loadable phase down-counter; expired while the count is zero.
// Load wins over decrement; counting stops at zero.
module disp_timer #(
  parameter int TMR_W = 8
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             load,
  input  logic [TMR_W-1:0] value,
  input  logic             en,
  output logic             expired
);

  logic [TMR_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (RESET) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/dispense_sequencer.sv
// Prime/pour/drip valve and pump sequencer for four bottles,
// with abort handling and per-channel saturating pour tallies.
module dispense_sequencer
  import disp_pkg::*;
#(
  parameter int PRIME_CYC = 4,
  parameter int POUR_CYC  = 16,
  parameter int DRIP_CYC  = 4,
  parameter int TMR_W     = 8,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 RESET,
  dispense_sequencer_if.slave  bus,
  input  logic [1:0]           rd_sel,
  output logic [CNT_W-1:0]     pour_cnt
);

  state_t           state;
  logic [1:0]       ch;
  logic             abort_q;
  logic [CNT_W-1:0] tally [NUM_CH];

  logic             start;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_en;
  logic             expired;

  assign start = (state == IDLE) && bus.out_ctrl
                 && is_onehot4(bus.out_sel);

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state)
      IDLE: if (start) begin
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(PRIME_CYC - 1);
      end
      PRIME: if (bus.out_ctrl && expired) begin
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(POUR_CYC - 1);
      end
      POUR: if (!bus.out_ctrl || expired) begin
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(DRIP_CYC - 1);
      end
      default: ;
    endcase
  end

  assign tmr_en = (state == PRIME) || (state == POUR)
                  || (state == DRIP);

  disp_timer #(.TMR_W(TMR_W)) u_timer (
    .clk     (clk),
    .RESET   (RESET),
    .load    (tmr_load),
    .value   (tmr_val),
    .en      (tmr_en),
    .expired (expired)
  );

  // Outputs are assigned alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state       <= IDLE;
      ch          <= '0;
      abort_q     <= 1'b0;
      bus.valve   <= '0;
      bus.pump_en <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.aborted <= 1'b0;
      bus.sel_err <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) tally[i] <= '0;
    end else begin
      bus.done    <= 1'b0;
      bus.aborted <= 1'b0;
      bus.sel_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= PRIME;
            ch        <= onehot_to_idx(bus.out_sel);
            abort_q   <= 1'b0;
            bus.valve <= bus.out_sel;
            bus.busy  <= 1'b1;
          end else if (bus.out_ctrl && bus.out_sel != '0) begin
            state       <= HOLD;
            bus.sel_err <= 1'b1;
            bus.busy    <= 1'b1;
          end
        end
        PRIME: begin
          if (!bus.out_ctrl) begin
            state       <= IDLE;
            bus.valve   <= '0;
            bus.busy    <= 1'b0;
            bus.aborted <= 1'b1;
          end else if (expired) begin
            state       <= POUR;
            bus.pump_en <= 1'b1;
          end
        end
        POUR: begin
          if (!bus.out_ctrl || expired) begin
            state       <= DRIP;
            bus.pump_en <= 1'b0;
            abort_q     <= !bus.out_ctrl;
          end
        end
        DRIP: begin
          if (expired) begin
            bus.valve <= '0;
            if (abort_q) begin
              state       <= HOLD;
              bus.aborted <= 1'b1;
            end else begin
              state    <= DONE;
              bus.done <= 1'b1;
              if (tally[ch] != {CNT_W{1'b1}})
                tally[ch] <= tally[ch] + 1'b1;
            end
          end
        end
        DONE: state <= HOLD;
        HOLD: begin
          if (!bus.out_ctrl) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pour_cnt = tally[rd_sel];

endmodule

// File: tb/tb_dispense_sequencer.sv
// Randomized self-checking bench for dispense_sequencer.
// Expected traces come from the latency rules of each transaction.
module tb_dispense_sequencer;

  localparam int P  = 4;
  localparam int U  = 16;
  localparam int D  = 4;
  localparam int T  = P + U + D;
  localparam int CW = 2;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    rd_sel;
  logic [CW-1:0] pour_cnt;

  int checks = 0;
  int fails  = 0;
  int tally_m [4];

  dispense_sequencer_if bus ();

  dispense_sequencer #(
    .PRIME_CYC(P), .POUR_CYC(U), .DRIP_CYC(D),
    .TMR_W(8), .CNT_W(CW)
  ) dut (
    .clk      (clk),
    .RESET    (rst),
    .bus      (bus),
    .rd_sel   (rd_sel),
    .pour_cnt (pour_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h t=%0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic logic [8:0] pack(
    input logic [3:0] v, input logic p, input logic b,
    input logic dn, input logic ab, input logic se
  );
    return {v, p, b, dn, ab, se};
  endfunction

  function automatic logic [8:0] observed();
    return pack(bus.valve, bus.pump_en, bus.busy,
                bus.done, bus.aborted, bus.sel_err);
  endfunction

  // Cycle (after the start edge) at which busy returns low.
  function automatic int txn_end(input logic [3:0] sel, input int a);
    if (!$onehot(sel)) return a;
    if (a <= P) return a;
    if (a <= P + U) return a + D + 1;
    return (a > T + 2) ? a : T + 2;
  endfunction

  // Expected outputs j cycles after the start edge, request
  // first seen low at edge a.
  function automatic logic [8:0] expect_out(
    input logic [3:0] sel, input int a, input int j
  );
    int e;
    e = txn_end(sel, a);
    if (!$onehot(sel))
      return pack(4'b0, 1'b0, j < e, 1'b0, 1'b0, j == 0);
    if (a <= P) begin
      if (j < a) return pack(sel, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      return pack(4'b0, 1'b0, 1'b0, 1'b0, j == a, 1'b0);
    end
    if (a <= P + U) begin
      if (j < a)
        return pack(sel, j >= P, 1'b1, 1'b0, 1'b0, 1'b0);
      if (j < a + D)
        return pack(sel, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      return pack(4'b0, 1'b0, j < e, 1'b0, j == a + D, 1'b0);
    end
    if (j < T)
      return pack(sel, (j >= P) && (j < P + U), 1'b1,
                  1'b0, 1'b0, 1'b0);
    return pack(4'b0, 1'b0, j < e, j == T, 1'b0, 1'b0);
  endfunction

  task automatic check_tallies(input string tag);
    for (int c = 0; c < 4; c++) begin
      rd_sel = 2'(c);
      #1;
      chk(tag, 32'(pour_cnt), 32'(tally_m[c]));
    end
  endtask

  // Called at a negedge while idle.
  task automatic run_txn(input logic [3:0] sel, input int a);
    int e;
    e = txn_end(sel, a);
    bus.out_ctrl = 1'b1;
    bus.out_sel  = sel;
    for (int j = 0; j <= e + 1; j++) begin
      @(posedge clk);
      #1;
      bus.out_ctrl = (j + 1 < a);
      bus.out_sel  = 4'($urandom);
      @(negedge clk);
      chk("cyc", 32'(observed()), 32'(expect_out(sel, a, j)));
    end
    if ($onehot(sel) && a > P + U) begin
      for (int c = 0; c < 4; c++)
        if (sel[c] && tally_m[c] < SAT) tally_m[c]++;
    end
    check_tallies("tally");
  endtask

  task automatic run_idle(input int n, input logic ctrl);
    bus.out_ctrl = ctrl;
    bus.out_sel  = 4'b0;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      chk("idle", 32'(observed()), 32'(0));
    end
    bus.out_ctrl = 1'b0;
  endtask

  initial begin
    logic [3:0] sel;
    int a;
    rst          = 1'b1;
    rd_sel       = 2'd0;
    bus.out_ctrl = 1'b0;
    bus.out_sel  = 4'b0;
    for (int c = 0; c < 4; c++) tally_m[c] = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out", 32'(observed()), 32'(0));
    check_tallies("rst_tally");

    run_idle(3, 1'b1);
    run_txn(4'b0100, T + 12);
    run_txn(4'b0010, 10);
    run_txn(4'b0001, 2);
    run_txn(4'b0011, 5);
    run_txn(4'b1000, T + 3);
    run_txn(4'b0100, P);
    run_txn(4'b0100, P + 1);
    run_txn(4'b0010, P + U);
    run_txn(4'b0010, P + U + 1);
    run_txn(4'b0001, T);
    run_txn(4'b1100, 1);
    for (int i = 0; i < 4; i++) run_txn(4'b0001, T + 1);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) < 7)
        sel = 4'b0001 << $urandom_range(0, 3);
      else
        sel = 4'($urandom_range(1, 15));
      a = $onehot(sel) ? $urandom_range(1, T + 6)
                       : $urandom_range(1, 6);
      run_txn(sel, a);
    end

    // Reset landing in the middle of a pour.
    bus.out_ctrl = 1'b1;
    bus.out_sel  = 4'b0001;
    for (int j = 0; j <= P + 2; j++) begin
      @(posedge clk);
      #1 bus.out_sel = 4'($urandom);
      @(negedge clk);
      chk("pre_rst", 32'(observed()),
          32'(expect_out(4'b0001, T + 10, j)));
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.out_ctrl = 1'b0;
    for (int c = 0; c < 4; c++) tally_m[c] = 0;
    @(negedge clk);
    chk("mid_rst", 32'(observed()), 32'(0));
    check_tallies("mid_rst_tally");
    run_idle(3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
